// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage hazard and forwarding unit.
// Tracks the destination tags of the instructions in the post-decode stages
// (entry 0 = EX ... entry NSTG-1 = WB). For every source operand it picks the
// youngest matching producer, forwards its result, or raises a load-use stall
// when that producer is a load whose data is not yet available.
// Optional feature: define SB_STALL_CNT_EN to build a saturating stall-cycle
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
module id_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int NSTG     = 3,
  parameter int LOAD_LAT = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                id_valid,
  input  logic [5*NSRC-1:0]                   id_src_idx,
  input  logic [NSRC-1:0]                     id_src_used,
  input  logic [XLEN*NSRC-1:0]                id_rf_data,
  input  logic                                id_wr,
  input  logic [4:0]                          id_rd,
  input  logic                                id_is_load,
  input  logic [XLEN*NSTG-1:0]                stg_data,
  input  logic                                pipe_hold,
  input  logic                                ex_flush,
  output logic [XLEN*NSRC-1:0]                src_value,
  output logic [$clog2(NSTG+1)*NSRC-1:0]      src_fwd_sel,
  output logic                                stall,
  output logic [31:0]                         stall_cnt
);

  localparam int SELW = $clog2(NSTG+1);

  // In-flight entry state: valid bit is control (reset), tag/load flag are data.
  logic       r_v  [NSTG];
  logic [4:0] r_rd [NSTG];
  logic       r_ld [NSTG];

  logic [XLEN*NSRC-1:0] w_src_value;
  logic [SELW*NSRC-1:0] w_sel;
  logic [NSRC-1:0]      w_blk;
  logic                 w_stall;
  logic                 w_new_v;

  // Youngest-hit search per source; entries are scanned oldest to youngest so
  // the last assignment made is the youngest match.
  always_comb begin
    w_src_value = id_rf_data;
    w_sel       = '0;
    w_blk       = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int j = NSTG-1; j >= 0; j--) begin
        if (id_src_used[k] && r_v[j] && (r_rd[j] != 5'd0) &&
            (r_rd[j] == id_src_idx[5*k +: 5])) begin
          if (r_ld[j] && (j < LOAD_LAT)) begin
            // Load data not ready yet: a younger hit always overrides older
            // forwardable ones, so fall back to the regfile and block.
            w_blk[k]                   = 1'b1;
            w_sel[SELW*k +: SELW]      = '0;
            w_src_value[XLEN*k +: XLEN] = id_rf_data[XLEN*k +: XLEN];
          end else begin
            w_blk[k]                   = 1'b0;
            w_sel[SELW*k +: SELW]      = SELW'(j + 1);
            w_src_value[XLEN*k +: XLEN] = stg_data[XLEN*j +: XLEN];
          end
        end
      end
    end
    w_stall = id_valid & ~ex_flush & (|w_blk);
    w_new_v = id_valid & id_wr & ~w_stall & ~ex_flush;
  end

  assign src_value   = w_src_value;
  assign src_fwd_sel = w_sel;
  assign stall       = w_stall;

  // Entry valid bits: shift toward WB; a flush kills the EX instruction as it
  // moves into entry 1, and the stalled/flushed ID slot enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NSTG; j++) r_v[j] <= 1'b0;
    end else if (!pipe_hold) begin
      r_v[0] <= w_new_v;
      for (int j = 1; j < NSTG; j++)
        r_v[j] <= (j == 1) ? (r_v[0] & ~ex_flush) : r_v[j-1];
    end
  end

  // Entry tags and load flags shift alongside the valid bits.
  always_ff @(posedge clk) begin
    if (!pipe_hold) begin
      r_rd[0] <= id_rd;
      r_ld[0] <= id_is_load;
      for (int j = 1; j < NSTG; j++) begin
        r_rd[j] <= r_rd[j-1];
        r_ld[j] <= r_ld[j-1];
      end
    end
  end

`ifdef SB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count effective stall cycles (frozen cycles excluded), saturating.
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall && !pipe_hold && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard (default parameters).
module tb_id_scoreboard;

  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int NSTG = 3;
  localparam int LOAD_LAT = 2;
  localparam int SELW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   id_valid;
  logic [5*NSRC-1:0]      id_src_idx;
  logic [NSRC-1:0]        id_src_used;
  logic [XLEN*NSRC-1:0]   id_rf_data;
  logic                   id_wr;
  logic [4:0]             id_rd;
  logic                   id_is_load;
  logic [XLEN*NSTG-1:0]   stg_data;
  logic                   pipe_hold;
  logic                   ex_flush;
  logic [XLEN*NSRC-1:0]   src_value;
  logic [SELW*NSRC-1:0]   src_fwd_sel;
  logic                   stall;
  logic [31:0]            stall_cnt;

  int checks = 0;
  int errors = 0;

  id_scoreboard #(.XLEN(XLEN), .NSRC(NSRC), .NSTG(NSTG), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_idx(id_src_idx),
    .id_src_used(id_src_used), .id_rf_data(id_rf_data), .id_wr(id_wr),
    .id_rd(id_rd), .id_is_load(id_is_load), .stg_data(stg_data),
    .pipe_hold(pipe_hold), .ex_flush(ex_flush), .src_value(src_value),
    .src_fwd_sel(src_fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int c);
`ifdef SB_STALL_CNT_EN
    return 32'(c);
`else
    return 32'd0 + 32'(c - c);
`endif
  endfunction

  typedef struct {
    logic       valid;
    logic [1:0] used;
    logic [4:0] s0, s1;
    logic       wr;
    logic [4:0] rd;
    logic       ld, hold, flush;
    logic       e_stall;
    logic       chk_sel;
    logic [1:0] e_sel0, e_sel1;
    int         e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] u, input logic [4:0] a,
                              input logic [4:0] b, input logic w, input logic [4:0] d,
                              input logic l, input logic h, input logic f, input logic es,
                              input logic cs, input logic [1:0] e0, input logic [1:0] e1,
                              input int ec);
    vec_t r;
    r.valid = v; r.used = u; r.s0 = a; r.s1 = b; r.wr = w; r.rd = d; r.ld = l;
    r.hold = h; r.flush = f; r.e_stall = es; r.chk_sel = cs; r.e_sel0 = e0;
    r.e_sel1 = e1; r.e_cnt = ec;
    return r;
  endfunction

  // Reference model: list of in-flight producers, youngest first.
  typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
  ent_t   q[$];
  longint m_cnt;

  function automatic logic [31:0] exp_val(input int k, input logic [1:0] sel);
    if (sel == 2'd0) return id_rf_data[XLEN*k +: XLEN];
    return stg_data[XLEN*(int'(sel)-1) +: XLEN];
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.valid; id_src_used = t.used; id_src_idx = {t.s1, t.s0};
    id_wr = t.wr; id_rd = t.rd; id_is_load = t.ld; pipe_hold = t.hold;
    ex_flush = t.flush;
  endtask

  vec_t tbl [24];

  initial begin
    rst = 1'b1; id_valid = 0; id_src_idx = '0; id_src_used = '0; id_wr = 0;
    id_rd = '0; id_is_load = 0; pipe_hold = 0; ex_flush = 0;
    id_rf_data = {32'hF000_0001, 32'hF000_0000};
    stg_data   = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

    tbl[0]  = mk(1, 2'b00, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(1, 2'b10, 0, 5, 1, 7, 1, 0, 0, 0, 1, 0, 2, 0);
    tbl[3]  = mk(1, 2'b01, 7, 0, 1, 8, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 2'b01, 7, 0, 1, 8, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[5]  = mk(1, 2'b01, 7, 0, 1, 8, 0, 0, 0, 0, 1, 3, 0, 2);
    tbl[6]  = mk(1, 2'b01, 8, 0, 1, 3, 0, 0, 0, 0, 1, 1, 0, 2);
    tbl[7]  = mk(1, 2'b01, 8, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 2);
    tbl[8]  = mk(1, 2'b11, 0, 3, 1, 3, 0, 0, 0, 0, 1, 0, 2, 2);
    tbl[9]  = mk(1, 2'b11, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
    tbl[10] = mk(1, 2'b01, 3, 0, 1, 9, 1, 0, 0, 0, 1, 2, 0, 2);
    tbl[11] = mk(1, 2'b00, 9, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    tbl[12] = mk(1, 2'b10, 0, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    tbl[13] = mk(1, 2'b10, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0, 3, 3);
    tbl[14] = mk(1, 2'b00, 0, 0, 1, 4, 1, 0, 0, 0, 1, 0, 0, 3);
    tbl[15] = mk(1, 2'b01, 4, 0, 1, 6, 0, 0, 1, 0, 0, 0, 0, 3);
    tbl[16] = mk(1, 2'b01, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
    tbl[17] = mk(1, 2'b00, 0, 0, 1, 7, 1, 0, 0, 0, 1, 0, 0, 3);
    tbl[18] = mk(1, 2'b01, 7, 0, 1, 8, 0, 0, 0, 1, 0, 0, 0, 3);
    for (int i = 19; i <= 22; i++)
      tbl[i] = mk(1, 2'b01, 7, 0, 1, 8, 0, 1, 0, 1, 0, 0, 0, 4);
    tbl[23] = mk(1, 2'b01, 7, 0, 1, 8, 0, 0, 0, 1, 0, 0, 0, 4);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    id_valid = 1; id_src_used = 2'b11; id_src_idx = {5'd5, 5'd5};
    #2;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_sel", 32'(src_fwd_sel), 32'd0);
    chk("reset_val0", src_value[31:0], 32'hF000_0000);
    chk("reset_val1", src_value[63:32], 32'hF000_0001);
    chk("reset_cnt", stall_cnt, 32'd0);
    id_valid = 0; id_src_used = '0;

    // Directed table
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_cnt", i), stall_cnt, cnt_exp(tbl[i].e_cnt));
      if (tbl[i].chk_sel) begin
        chk($sformatf("tbl%0d_sel0", i), 32'(src_fwd_sel[1:0]), 32'(tbl[i].e_sel0));
        chk($sformatf("tbl%0d_sel1", i), 32'(src_fwd_sel[3:2]), 32'(tbl[i].e_sel1));
        chk($sformatf("tbl%0d_val0", i), src_value[31:0], exp_val(0, tbl[i].e_sel0));
        chk($sformatf("tbl%0d_val1", i), src_value[63:32], exp_val(1, tbl[i].e_sel1));
      end
    end

    // Reset in the middle of a load-use stall
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_sel", 32'(src_fwd_sel), 32'd0);
    chk("rst_mid_cnt", stall_cnt, 32'd0);

    // Randomized phase against the queue model
    q.delete();
    for (int j = 0; j < NSTG; j++) q.push_back('{v: 1'b0, rd: 5'd0, ld: 1'b0});
    m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      logic       e_stall;
      logic [1:0] e_sel [NSRC];
      bit         blk [NSRC];
      ent_t       n;
      @(negedge clk);
      rst         = ($urandom_range(63) == 0);
      id_valid    = ($urandom_range(7) != 0);
      id_src_used = 2'($urandom_range(3));
      id_src_idx  = {5'($urandom_range(7)), 5'($urandom_range(7))};
      id_wr       = ($urandom_range(3) != 0);
      id_rd       = 5'($urandom_range(7));
      id_is_load  = ($urandom_range(2) == 0);
      pipe_hold   = ($urandom_range(7) == 0);
      ex_flush    = ($urandom_range(9) == 0);
      id_rf_data  = {$urandom, $urandom};
      stg_data    = {$urandom, $urandom, $urandom};
      #2;
      e_stall = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
        int hit;
        hit = -1;
        for (int j = 0; j < NSTG; j++)
          if (hit < 0 && id_src_used[k] && q[j].v && q[j].rd != 0 &&
              q[j].rd == id_src_idx[5*k +: 5]) hit = j;
        blk[k]   = (hit >= 0) && q[hit].ld && (hit < LOAD_LAT);
        e_sel[k] = (hit >= 0 && !blk[k]) ? 2'(hit + 1) : 2'd0;
        if (blk[k]) e_stall = 1'b1;
      end
      e_stall = e_stall & id_valid & ~ex_flush;
      chk($sformatf("rnd%0d_stall", c), 32'(stall), 32'(e_stall));
      chk($sformatf("rnd%0d_cnt", c), stall_cnt, cnt_exp(int'(m_cnt)));
      if (!e_stall)
        for (int k = 0; k < NSRC; k++)
          if (!blk[k]) begin
            chk($sformatf("rnd%0d_sel%0d", c, k), 32'(src_fwd_sel[SELW*k +: SELW]), 32'(e_sel[k]));
            chk($sformatf("rnd%0d_val%0d", c, k), src_value[XLEN*k +: XLEN], exp_val(k, e_sel[k]));
          end
      // Model update for the coming clock edge
      if (rst) begin
        foreach (q[j]) q[j].v = 1'b0;
        m_cnt = 0;
      end else if (!pipe_hold) begin
        if (e_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        n.v = id_valid & id_wr & ~e_stall & ~ex_flush;
        n.rd = id_rd;
        n.ld = id_is_load;
        q.push_front(n);
        q[1].v = q[1].v & ~ex_flush;
        void'(q.pop_back());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised decode-stage hazard and forwarding unit that replaces the hard-wired three-stage compare logic inside the decode stage. It keeps its own shift-register of in-flight destination tags, one entry per post-decode stage (EX, MEM, WB, …). From that state it generates per-source forwarding selects, forwarded operand values and a load-use stall. It sits between the register file read ports and the ID/EX pipeline register.

## Interface
Parameters:
- XLEN, 32, datapath width
- NSRC, 2, number of source operands checked per instruction
- NSTG, 3, tracked post-decode stages; entry 0 = EX, entry NSTG-1 = WB
- LOAD_LAT, 2, first entry index from which a load result is forwardable; must satisfy 1 ≤ LOAD_LAT ≤ NSTG-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  instruction in ID is valid
- id_src_idx  in  5*NSRC  source register indices, src k at [5k+4:5k]
- id_src_used  in  NSRC  source k is actually read by the instruction (decoder mask)
- id_rf_data  in  XLEN*NSRC  register-file read data per source
- id_wr  in  1  instruction writes rd
- id_rd  in  5  destination index
- id_is_load  in  1  instruction is a load
- stg_data  in  XLEN*NSTG  result currently available in entry j
- pipe_hold  in  1  whole pipeline frozen (memory wait); scoreboard state holds
- ex_flush  in  1  kill instruction in EX and the one in ID (taken branch)
- src_value  out  XLEN*NSRC  forwarded or register-file operand
- src_fwd_sel  out  (clog2(NSTG+1))*NSRC  0 = regfile, j+1 = forwarded from entry j
- stall  out  1  load-use hazard; ID must hold, bubble goes to EX
- stall_cnt  out  32  stall-cycle counter (only with SB_STALL_CNT_EN)

## Operation
- State: NSTG entries {v, rd[4:0], ld}. An entry is live if v=1 and rd≠0.
- Match: source k hits entry j if id_src_used[k] and the entry is live and rd==id_src_idx[k]. The lowest j (youngest) wins.
- Forward: on a youngest hit at j with (ld=0 or j ≥ LOAD_LAT), src_value[k] = stg_data[j] and src_fwd_sel[k] = j+1. With no hit, src_value[k] = id_rf_data[k] and sel = 0.
- Stall: stall = id_valid & ~ex_flush & OR over k of (youngest hit at j with ld=1 and j < LOAD_LAT). When stalled, src_value is don't-care.
- An older non-load match behind a younger load never suppresses the stall.
- Update each cycle unless pipe_hold:
  - Entries shift: entry j+1 ← entry j.
  - Entry 0 ← {id_valid & id_wr & ~stall & ~ex_flush, id_rd, id_is_load}.
- ex_flush with no pipe_hold: the shifting entry 0 goes to entry 1 invalid, because the EX instruction is killed. The new entry 0 is a bubble.
- pipe_hold has priority over ex_flush and rst-free updates: no state changes. Outputs are still evaluated combinationally.
- rd=0 is never live; src index 0 is never matched.

## Timing
- Forwarding and stall are purely combinational from the current state and ID inputs: same-cycle decision, zero latency.
- Entry state updates on the clk rising edge.
- A load issued at cycle t occupies entry j at cycle t+1+j. A dependent instruction in ID stalls while the load sits in entries 0..LOAD_LAT-1. This gives exactly LOAD_LAT stall cycles for a back-to-back dependency, and LOAD_LAT-1 stall cycles with one independent instruction between.
- Reset: all entries v=0. src_fwd_sel=0, src_value=id_rf_data, stall=0, stall_cnt=0.
- Reset asserted mid-stall clears all entries. stall deasserts in the same cycle the reset takes effect.

## Configuration
- SB_STALL_CNT_EN defined: stall_cnt increments on every clk edge where stall=1 and pipe_hold=0. It saturates at 32'hFFFF_FFFF and clears on rst.
- Not defined: stall_cnt is tied to 0 and no counter flops are built.

## Test plan
- Defaults. ALU op writes x5, then the next instruction reads x5: src_fwd_sel=1, src_value=stg_data[0], stall=0.
- Load to x7, then an immediate dependent reading x7 on src0: stall=1 for 2 cycles. Cycle 3: sel=3 (entry 2), stall=0. With SB_STALL_CNT_EN, stall_cnt=2.
- x3 written by entry 0 and entry 2 simultaneously: youngest wins, sel=1. Reading x0 while an entry has rd=0: sel=0, value=id_rf_data.
- Load to x9 followed by a reader with id_src_used=0 for that source: stall=0 and sel=0.
- Load in entry 0, dependent in ID, with ex_flush=1: stall=0. Next cycle entry 1 is invalid and no forward occurs.
- pipe_hold=1 for 4 cycles during a load-use stall: entries are frozen, stall stays 1, and stall_cnt is unchanged. Applying rst then gives stall=0 on the next cycle.
